// File: rtl/seq_deser_pkg.sv
// Shared definitions for the 1-bit to 128-bit serial deserializer.
// Optional build macro: SEQ_DESER_MSB_FIRST_EN
//   undefined (default): stream bit k lands in out[k]
//   defined            : stream bit k lands in out[127-k]
package seq_deser_pkg;

    localparam int NBITS = 128;
    localparam int IDX_W = 7;

    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NBITS - 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    // Map the stream position (write index) onto a bit of the output word.
    function automatic logic [IDX_W-1:0] bit_pos(input logic [IDX_W-1:0] idx);
`ifdef SEQ_DESER_MSB_FIRST_EN
        // 127 - idx is the bitwise complement for a 7-bit index
        return ~idx;
`else
        return idx;
`endif
    endfunction

endpackage

// File: rtl/seq_deser_ctrl.sv
// Control path of the deserializer: FILL/FULL state machine and the
// 7-bit write index. The datapath (word buffer) lives in the top.
module seq_deser_ctrl
    import seq_deser_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    input  logic             out_rdy,
    output logic             in_rdy,
    output logic             out_val,
    output logic             wr_en,
    output logic [IDX_W-1:0] idx
);

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic             out_val_q;

    // Handshake decode: while a word is held, a new bit can only enter
    // in the same cycle the held word is drained.
    always_comb begin
        in_rdy = 1'b1;
        case (state_q)
            FILL:    in_rdy = 1'b1;
            FULL:    in_rdy = out_rdy;
            default: in_rdy = 1'b1;
        endcase
    end

    assign wr_en   = in_val & in_rdy;
    assign idx     = idx_q;
    assign out_val = out_val_q;

    // State machine and write index; out_val is registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FILL;
            idx_q     <= IDX_ZERO;
            out_val_q <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (wr_en) begin
                        // Index wraps to zero after the last bit of a word
                        idx_q <= idx_q + IDX_ONE;
                        if (idx_q == IDX_MAX) begin
                            state_q   <= FULL;
                            out_val_q <= 1'b1;
                        end else begin
                            state_q   <= FILL;
                            out_val_q <= 1'b0;
                        end
                    end else begin
                        state_q   <= FILL;
                        out_val_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (out_rdy) begin
                        // Drain; a bit accepted in the same cycle becomes bit 0
                        state_q   <= FILL;
                        out_val_q <= 1'b0;
                        if (in_val) begin
                            idx_q <= IDX_ONE;
                        end else begin
                            idx_q <= IDX_ZERO;
                        end
                    end else begin
                        state_q   <= FULL;
                        out_val_q <= 1'b1;
                        idx_q     <= idx_q;
                    end
                end
                default: begin
                    state_q   <= FILL;
                    idx_q     <= IDX_ZERO;
                    out_val_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/seq_deser_1b_to_128b.sv
// 1-bit to 128-bit deserializer (top). Holds the word buffer and the
// bit-ordering mux; control comes from seq_deser_ctrl.
// Optional build macro: SEQ_DESER_MSB_FIRST_EN (first stream bit -> out[127]).
module seq_deser_1b_to_128b
    import seq_deser_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_,
    input  logic             in_val,
    output logic             in_rdy,
    output logic [NBITS-1:0] out,
    output logic             out_val,
    input  logic             out_rdy
);

    logic             wr_en_s;
    logic [IDX_W-1:0] idx_s;
    logic [NBITS-1:0] buf_q;
    logic [NBITS-1:0] buf_d;

    seq_deser_ctrl u_ctrl (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .out_rdy (out_rdy),
        .in_rdy  (in_rdy),
        .out_val (out_val),
        .wr_en   (wr_en_s),
        .idx     (idx_s)
    );

    // Next buffer value: write the incoming bit at its mapped position;
    // untouched bits keep stale contents from the previous word.
    always_comb begin
        buf_d = buf_q;
        if (wr_en_s) begin
            buf_d[bit_pos(idx_s)] = in_;
        end else begin
            buf_d = buf_q;
        end
    end

    // Word buffer register, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_q <= {NBITS{1'b0}};
        end else begin
            buf_q <= buf_d;
        end
    end

    assign out = buf_q;

endmodule

// File: tb/tb_seq_deser_1b_to_128b.sv
// Self-checking bench for seq_deser_1b_to_128b: a word-level reference
// model checked every cycle, plus directed scenarios with literal words.
module tb_seq_deser_1b_to_128b;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_ = 1'b0;
    logic         in_val = 1'b0;
    logic         out_rdy = 1'b0;
    logic         in_rdy;
    logic         out_val;
    logic [127:0] out;

    int tests = 0;
    int fails = 0;

    seq_deser_1b_to_128b dut (
        .clk     (clk),
        .reset   (reset),
        .in_     (in_),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .out     (out),
        .out_val (out_val),
        .out_rdy (out_rdy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // m_cnt = number of bits collected in the current word (128 = word held)
    logic [127:0]   m_word = 128'h0;
    int             m_cnt  = 0;
    logic [127:0]   words[$];

    function automatic int pos(input int k);
`ifdef SEQ_DESER_MSB_FIRST_EN
        return 127 - k;
`else
        return k;
`endif
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_word <= 128'h0;
            m_cnt  <= 0;
        end else if (m_cnt < 128) begin
            if (in_val) begin
                m_word[pos(m_cnt)] <= in_;
                m_cnt <= m_cnt + 1;
            end
        end else if (out_rdy) begin
            if (in_val) begin
                m_word[pos(0)] <= in_;
                m_cnt <= 1;
            end else begin
                m_cnt <= 0;
            end
        end
    end

    task automatic chk1(input string name, input logic got, input logic exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk1("cyc_in_rdy", in_rdy, (m_cnt == 128) ? out_rdy : 1'b1);
        chk1("cyc_out_val", out_val, (m_cnt == 128));
        chkw("cyc_out", out, m_word);
        if (out_val && out_rdy) words.push_back(out);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic v, input logic b, input logic r);
        in_val  = v;
        in_     = b;
        out_rdy = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_val  = 1'b0;
        in_     = 1'b0;
        out_rdy = 1'b0;
        reset   = 1'b0;
        #1;
        chkw("rst_out", out, 128'h0);
        chk1("rst_out_val", out_val, 1'b0);
        chk1("rst_in_rdy", in_rdy, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] held;
        logic [127:0] exp_w;
        logic [127:0] lsb_w;
        int           k;
        int           cyc;
        int           bubbles;
        logic         v;
        logic         b;

        #2;
        do_reset();

        // Alternating 1,0,1,0... with consumer stalled
        for (int i = 0; i < 128; i++) step(1'b1, (i % 2) == 0, 1'b0);
        chk1("alt_out_val", out_val, 1'b1);
        chk1("alt_in_rdy", in_rdy, 1'b0);
`ifdef SEQ_DESER_MSB_FIRST_EN
        chkw("alt_word", out, 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA);
`else
        chkw("alt_word", out, 128'h55555555555555555555555555555555);
`endif

        // Hold with in_val=1 and out_rdy=0: nothing moves
        held = out;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'($urandom % 2), 1'b0);
            chkw("hold_out", out, held);
            chk1("hold_in_rdy", in_rdy, 1'b0);
        end
        // Simultaneous drain and accept of a 1
        step(1'b1, 1'b1, 1'b1);
        chk1("drain_out_val", out_val, 1'b0);
        chk1("drain_bit0", out[pos(0)], 1'b1);
        out_rdy = 1'b0;
        in_val  = 1'b0;

        // Back-to-back words, no bubbles
        do_reset();
        words.delete();
        bubbles = 0;
        for (int i = 0; i < 256; i++) begin
            in_val  = 1'b1;
            in_     = (i < 128) ? 1'b1 : ((i - 128) == 5);
            out_rdy = 1'b1;
            #1;
            if (!in_rdy) bubbles++;
            @(posedge clk);
            #1;
        end
        in_val = 1'b0;
        @(posedge clk);
        #1;
        out_rdy = 1'b0;
        chk1("b2b_no_bubbles", bubbles == 0, 1'b1);
        chk1("b2b_two_words", words.size() == 2, 1'b1);
        if (words.size() == 2) begin
            chkw("b2b_word1", words[0], 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF);
`ifdef SEQ_DESER_MSB_FIRST_EN
            chkw("b2b_word2", words[1], 128'h04000000000000000000000000000000);
`else
            chkw("b2b_word2", words[1], 128'h00000000000000000000000000000020);
`endif
        end

        // Counter pattern with random in_val gaps
        do_reset();
        k = 0;
        cyc = 0;
        while (k < 128 && cyc < 2000) begin
            chk1("cnt_no_early_val", out_val, 1'b0);
            v = 1'($urandom % 2);
            b = 1'(((k / 8) >> (k % 8)) & 1);
            step(v, b, (k == 127) ? 1'b0 : 1'($urandom % 2));
            if (v) k++;
            cyc++;
        end
        in_val = 1'b0;
        chk1("cnt_completed", k == 128, 1'b1);
        chk1("cnt_out_val", out_val, 1'b1);
        lsb_w = 128'h0F0E0D0C0B0A09080706050403020100;
`ifdef SEQ_DESER_MSB_FIRST_EN
        for (int i = 0; i < 128; i++) exp_w[127 - i] = lsb_w[i];
`else
        exp_w = lsb_w;
`endif
        chkw("cnt_word", out, exp_w);

        // Asynchronous reset mid-word
        do_reset();
        for (int i = 0; i < 60; i++) step(1'b1, 1'($urandom % 2), 1'b0);
        in_val = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chkw("arst_out", out, 128'h0);
        chk1("arst_out_val", out_val, 1'b0);
        chk1("arst_in_rdy", in_rdy, 1'b1);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 128; i++) step(1'b1, 1'b1, 1'b0);
        in_val = 1'b0;
        chk1("arst_refill_val", out_val, 1'b1);
        chkw("arst_refill_word", out, 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF);

        // Fully random traffic, checked by the per-cycle compare
        do_reset();
        for (int i = 0; i < 3000; i++)
            step(1'($urandom % 2), 1'($urandom % 2), ($urandom % 4) != 0);

        // Single 1 then 127 zeros: ordering check
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 127; i++) step(1'b1, 1'b0, 1'b0);
        in_val = 1'b0;
        chk1("order_out_val", out_val, 1'b1);
`ifdef SEQ_DESER_MSB_FIRST_EN
        chkw("order_word", out, 128'h80000000000000000000000000000000);
`else
        chkw("order_word", out, 128'h00000000000000000000000000000001);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
